// File: rtl/dm_resp.sv
// -----------------------------------------------------------------------------
// dm_resp
// Data-memory responder for the execute phase. It accepts one read or write
// request at a time from the sequencer, holds it for WAIT wait states, then
// performs the access against a 2^ADDR_W x 16-bit memory. While a transaction
// is in flight the sequencer is stalled and any further requests are dropped.
// Malformed requests are rejected with a one-cycle error pulse. A malformed
// request either asserts read and write together or has address bits above
// the memory index set.
//
// Parameters
//   ADDR_W       memory index width; depth is 2^ADDR_W words
//   WAIT         number of wait states before the access (0..7)
//
// Ports
//   clk_exe      execute-phase clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   dg_dm_add    16-bit address from the DAG
//   ps_dm_rd_en  read request from the sequencer
//   ps_dm_wrt_en write request from the sequencer
//   bc_dt        write data from the bus
//   dm_bc_dt     registered read data to the bus, held between reads
//   dm_rd_vld    one-cycle pulse when dm_bc_dt carries new read data
//   dm_ps_stall  busy indication, high whenever a transaction is in flight
//   dm_err       one-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module dm_resp #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1
) (
    input  logic        clk_exe,
    input  logic        rst_n,
    input  logic [15:0] dg_dm_add,
    input  logic        ps_dm_rd_en,
    input  logic        ps_dm_wrt_en,
    input  logic [15:0] bc_dt,
    output logic [15:0] dm_bc_dt,
    output logic        dm_rd_vld,
    output logic        dm_ps_stall,
    output logic        dm_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACC
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               rd_vld_q, rd_vld_d;
    logic               err_q, err_d;

    // Memory contents are deliberately left uninitialised across reset.
    logic [15:0]        mem [DEPTH];

    logic               req;
    logic               conflict;
    logic               out_of_range;
    logic               mem_we;
    logic [15:0]        upper_bits;

    assign req          = ps_dm_rd_en | ps_dm_wrt_en;
    assign conflict     = ps_dm_rd_en & ps_dm_wrt_en;
    // Shifting out the index bits leaves only the bits that must be zero;
    // this also degenerates cleanly to "never out of range" when ADDR_W = 16.
    assign upper_bits   = dg_dm_add >> ADDR_W;
    assign out_of_range = |upper_bits;

    // The write strobe comes from the registered state. An async reset during
    // ACC therefore clears it before the next edge and the write is dropped.
    assign mem_we       = (state_q == ST_ACC) && is_wr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        is_wr_d  = is_wr_q;
        rdata_d  = rdata_q;
        rd_vld_d = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (conflict || out_of_range) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = dg_dm_add[ADDR_W-1:0];
                        wdata_d = bc_dt;
                        is_wr_d = ps_dm_wrt_en;
                        if (WAIT > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = 3'(WAIT);
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Leave on the edge where the count reaches 1, so WAIT cycles
                // are spent here in total.
                if (cnt_q <= 3'd1) begin
                    state_d = ST_ACC;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACC: begin
                if (!is_wr_q) begin
                    rdata_d  = mem[idx_q];
                    rd_vld_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_exe or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            wdata_q  <= 16'd0;
            is_wr_q  <= 1'b0;
            rdata_q  <= 16'd0;
            rd_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            rdata_q  <= rdata_d;
            rd_vld_q <= rd_vld_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_exe) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign dm_bc_dt    = rdata_q;
    assign dm_rd_vld   = rd_vld_q;
    assign dm_ps_stall = (state_q != ST_IDLE);
    assign dm_err      = err_q;

endmodule

// File: tb/tb_dm_resp.sv
// -----------------------------------------------------------------------------
// tb_dm_resp
// Self-checking bench for dm_resp. The main instance uses WAIT=2 and ADDR_W=8.
// A second instance with WAIT=0 covers the zero-wait-state timing. The main
// instance is compared every cycle against a transaction-level reference.
// That reference holds an array memory, a countdown of remaining busy cycles,
// and the pending operation.
// -----------------------------------------------------------------------------
module tb_dm_resp;

    localparam int ADDR_W      = 8;
    localparam int WAIT_STATES = 2;
    localparam int DEPTH       = 1 << ADDR_W;

    logic        clk_exe;
    logic        rst_n;
    logic [15:0] dg_dm_add;
    logic        ps_dm_rd_en;
    logic        ps_dm_wrt_en;
    logic [15:0] bc_dt;
    logic [15:0] dm_bc_dt;
    logic        dm_rd_vld;
    logic        dm_ps_stall;
    logic        dm_err;

    logic [15:0] z_add;
    logic        z_rd;
    logic        z_wr;
    logic [15:0] z_dt;
    logic [15:0] z_dout;
    logic        z_vld;
    logic        z_stall;
    logic        z_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [15:0] ref_mem [DEPTH];
    int          busy_left;
    logic        pend_wr;
    int          pend_idx;
    logic [15:0] pend_data;
    logic [15:0] exp_dout;
    logic        exp_vld;
    logic        exp_err;

    dm_resp #(.ADDR_W(ADDR_W), .WAIT(WAIT_STATES)) dut (
        .clk_exe      (clk_exe),
        .rst_n        (rst_n),
        .dg_dm_add    (dg_dm_add),
        .ps_dm_rd_en  (ps_dm_rd_en),
        .ps_dm_wrt_en (ps_dm_wrt_en),
        .bc_dt        (bc_dt),
        .dm_bc_dt     (dm_bc_dt),
        .dm_rd_vld    (dm_rd_vld),
        .dm_ps_stall  (dm_ps_stall),
        .dm_err       (dm_err)
    );

    dm_resp #(.ADDR_W(ADDR_W), .WAIT(0)) dut0 (
        .clk_exe      (clk_exe),
        .rst_n        (rst_n),
        .dg_dm_add    (z_add),
        .ps_dm_rd_en  (z_rd),
        .ps_dm_wrt_en (z_wr),
        .bc_dt        (z_dt),
        .dm_bc_dt     (z_dout),
        .dm_rd_vld    (z_vld),
        .dm_ps_stall  (z_stall),
        .dm_err       (z_err)
    );

    initial begin
        clk_exe = 1'b0;
        forever #5 clk_exe = ~clk_exe;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // One rising edge of the reference. A request is taken only when nothing
    // is in flight. It then completes WAIT_STATES+1 edges later, while the
    // outputs show busy throughout.
    task automatic modelEdge(input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [15:0] data,
                             input logic rst);
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (!rst) begin
            busy_left = 0;
            exp_dout  = 16'd0;
        end else if (busy_left == 0) begin
            if (rd || wr) begin
                if ((rd && wr) || (int'(addr) >= DEPTH)) begin
                    exp_err = 1'b1;
                end else begin
                    busy_left = WAIT_STATES + 1;
                    pend_wr   = wr;
                    pend_idx  = int'(addr);
                    pend_data = data;
                end
            end
        end else begin
            busy_left--;
            if (busy_left == 0) begin
                if (pend_wr) begin
                    ref_mem[pend_idx] = pend_data;
                end else begin
                    exp_dout = ref_mem[pend_idx];
                    exp_vld  = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] data,
                                 input logic rst);
        ps_dm_rd_en  = rd;
        ps_dm_wrt_en = wr;
        dg_dm_add    = addr;
        bc_dt        = data;
        rst_n        = rst;
        @(posedge clk_exe);
        modelEdge(rd, wr, addr, data, rst);
        #1;
        checkOutput("stall", 16'(dm_ps_stall), 16'(busy_left != 0));
        checkOutput("rd_vld", 16'(dm_rd_vld), 16'(exp_vld));
        checkOutput("err", 16'(dm_err), 16'(exp_err));
        checkOutput("dout", dm_bc_dt, exp_dout);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    endtask

    initial begin
        int n;
        logic [15:0] old_val;
        logic [15:0] a;
        logic [15:0] d;
        int r;

        busy_left = 0;
        pend_wr   = 1'b0;
        pend_idx  = 0;
        pend_data = 16'd0;
        exp_dout  = 16'd0;
        exp_vld   = 1'b0;
        exp_err   = 1'b0;
        z_add     = 16'd0;
        z_rd      = 1'b0;
        z_wr      = 1'b0;
        z_dt      = 16'd0;

        // Reset state, with a request present that must be ignored.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h5555, 1'b0);
        idleCycle();

        // Give every location a known value.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i), 16'($urandom), 1'b1);
            for (int k = 0; k < WAIT_STATES + 1; k++) idleCycle();
        end

        // Write then read back, measuring stall length and read latency.
        applyStimulus(1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (!dm_ps_stall) break;
            n++;
            idleCycle();
        end
        checkOutput("wr_stall_cycles", 16'(n), 16'd3);
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'd0, 1'b1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (dm_rd_vld) break;
            n++;
            idleCycle();
        end
        checkOutput("rd_latency", 16'(n), 16'd3);
        checkOutput("rd_beef", dm_bc_dt, 16'hBEEF);
        idleCycle();

        // Read and write together are rejected without touching memory.
        applyStimulus(1'b1, 1'b1, 16'h0012, 16'h0BAD, 1'b1);
        checkOutput("conflict_err", 16'(dm_err), 16'd1);
        idleCycle();
        checkOutput("conflict_err_gone", 16'(dm_err), 16'd0);
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'd0, 1'b1);
        for (int k = 0; k < WAIT_STATES + 1; k++) idleCycle();
        checkOutput("conflict_mem_kept", dm_bc_dt, 16'hBEEF);

        // An out-of-range read is rejected and the read data is held.
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'd0, 1'b1);
        checkOutput("oor_err", 16'(dm_err), 16'd1);
        checkOutput("oor_hold", dm_bc_dt, 16'hBEEF);
        idleCycle();

        // Requests made while busy are dropped.
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'hCAFE, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0041, 16'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0041, 16'hDEAD, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0041, 16'hDEAD, 1'b1);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'd0, 1'b1);
        for (int k = 0; k < WAIT_STATES + 1; k++) idleCycle();
        checkOutput("busy_first_done", dm_bc_dt, 16'hCAFE);

        // Reset during the wait phase drops the pending write.
        old_val = ref_mem[5];
        applyStimulus(1'b0, 1'b1, 16'h0005, 16'h1234, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("rst_dout", dm_bc_dt, 16'd0);
        checkOutput("rst_stall", 16'(dm_ps_stall), 16'd0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'd0, 1'b1);
        for (int k = 0; k < WAIT_STATES + 1; k++) idleCycle();
        checkOutput("rst_drop_rd", dm_bc_dt, old_val);

        // Zero-wait-state instance: write then read one location.
        z_wr = 1'b1; z_add = 16'h0033; z_dt = 16'hA5A5;
        idleCycle();
        checkOutput("w0_stall_on", 16'(z_stall), 16'd1);
        z_wr = 1'b0;
        idleCycle();
        checkOutput("w0_stall_off", 16'(z_stall), 16'd0);
        z_rd = 1'b1;
        idleCycle();
        checkOutput("w0_rd_stall", 16'(z_stall), 16'd1);
        checkOutput("w0_rd_novld", 16'(z_vld), 16'd0);
        z_rd = 1'b0;
        idleCycle();
        checkOutput("w0_rd_vld", 16'(z_vld), 16'd1);
        checkOutput("w0_rd_data", z_dout, 16'hA5A5);
        checkOutput("w0_rd_idle", 16'(z_stall), 16'd0);
        z_add = 16'd0; z_dt = 16'd0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            else                           a = 16'($urandom_range(0, DEPTH - 1));
            d = 16'($urandom);
            applyStimulus((r <= 3) || (r == 7), (r >= 4) && (r <= 7), a, d,
                          $urandom_range(0, 99) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
